wash_cycle_sequencer: RTL and testbench

//  Top-level sequencer for one wash program. Latches the selected mode at start.

---
 rtl/wash_pkg.sv | 42 ++++
 rtl/wash_watchdog.sv | 33 +++
 rtl/wash_cycle_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the wash cycle sequencer.
package wash_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOAK,
      S_WASH,
      S_RINSE,
      S_SPIN,
      S_GAP,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [1:0] PH_SOAK  = 2'b00;
   localparam logic [1:0] PH_WASH  = 2'b01;
   localparam logic [1:0] PH_RINSE = 2'b10;
   localparam logic [1:0] PH_SPIN  = 2'b11;

   localparam logic [3:0] QUICK     = 4'b1000;
   localparam logic [3:0] NORMAL    = 4'b0100;
   localparam logic [3:0] HEAVY     = 4'b0010;
   localparam logic [3:0] SPIN_ONLY = 4'b0001;

   function automatic logic is_onehot4(input logic [3:0] m);
      return (m != 4'b0000) && ((m & (m - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic is_phase(input state_t s);
      return s inside {S_SOAK, S_WASH, S_RINSE, S_SPIN};
   endfunction

   function automatic state_t phase_state(input logic [1:0] ph);
      case (ph)
         PH_SOAK:  return S_SOAK;
         PH_WASH:  return S_WASH;
         PH_RINSE: return S_RINSE;
         default:  return S_SPIN;
      endcase
   endfunction

endpackage

// File: rtl/wash_watchdog.sv
// Stuck-timer watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count would reach WDOG_CYCLES.
module wash_watchdog #(
   parameter int WDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(WDOG_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear wins over count; count holds when not enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash program sequencer: latches the program, steps the phase timer and
// drives the actuators, door lock and status flags.
//
//   state | meaning
//   IDLE  | waiting for start, door unlocked
//   SOAK  | fill valve, timer running on phase 00
//   WASH  | valve + motor, phase 01
//   RINSE | valve + motor, phase 10
//   SPIN  | motor + drain, phase 11
//   GAP   | one idle cycle between phases, timer cleared
//   DONE  | program finished, DONE_HOLD cycles before unlocking
//   FAULT | invalid start or stuck timer, waits for fault_clr with mains
module wash_cycle_sequencer
   import wash_pkg::*;
#(
   parameter int WDOG_CYCLES = 1024,
   parameter int DONE_HOLD   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode1,
   input  logic       mode2,
   input  logic       mode3,
   input  logic       mode4,
   input  logic       power_on,
   input  logic       door_closed,
   input  logic       abort,
   input  logic       fault_clr,
   input  logic       timer_done_i,
   output logic       tmr_enable,
   output logic       tmr_power_on,
   output logic [1:0] tmr_phase_sel,
   output logic [3:0] tmr_mode,
   output logic       valve_open,
   output logic       motor_on,
   output logic       drain_on,
   output logic       door_lock,
   output logic       busy,
   output logic       cycle_done,
   output logic       fault
);

   localparam int HW = $clog2(DONE_HOLD + 1);

   state_t        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [3:0]    mode_q, mode_d;
   logic          last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;

   logic tmr_enable_q, tmr_power_on_q, valve_q, motor_q, drain_q;
   logic door_lock_q, busy_q, cycle_done_q, fault_q;

   logic       run_ok, in_phase, wd_expire;
   logic [3:0] mode_in;

   assign run_ok   = power_on & door_closed;
   assign mode_in  = {mode1, mode2, mode3, mode4};
   assign in_phase = is_phase(state_q);

   // Watchdog is cleared whenever we are outside a phase, so it restarts at
   // every phase entry and freezes while mains or door drop out.
   wash_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (~in_phase),
      .en_i     (in_phase & run_ok),
      .expire_o (wd_expire)
   );

   // Next-state logic; phase_q already points at the upcoming phase while in GAP.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      mode_d  = mode_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (start && run_ok) begin
               if (is_onehot4(mode_in)) begin
                  mode_d = mode_in;
                  last_d = 1'b0;
                  if (mode_in == SPIN_ONLY) begin
                     state_d = S_SPIN;
                     phase_d = PH_SPIN;
                  end else begin
                     state_d = S_SOAK;
                     phase_d = PH_SOAK;
                  end
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (wd_expire) begin
               state_d = S_FAULT;
            end else if (timer_done_i) begin
               state_d = S_GAP;
               last_d  = (state_q == S_SPIN);
               if (state_q != S_SPIN) phase_d = phase_q + 2'd1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_q) begin
               state_d = S_DONE;
               hold_d  = HW'(DONE_HOLD - 1);
            end else begin
               state_d = phase_state(phase_q);
            end
         end
         S_DONE: begin
            if (abort || hold_q == '0) state_d = S_IDLE;
            else                       hold_d  = hold_q - HW'(1);
         end
         S_FAULT: begin
            if (fault_clr && power_on) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Returning to IDLE drops the latched program so the timer sees a clean bus.
      if (state_d == S_IDLE) begin
         phase_d = PH_SOAK;
         mode_d  = '0;
      end
   end

   // State and registered outputs, all derived from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         phase_q        <= PH_SOAK;
         mode_q         <= '0;
         last_q         <= 1'b0;
         hold_q         <= '0;
         tmr_enable_q   <= 1'b0;
         tmr_power_on_q <= 1'b0;
         valve_q        <= 1'b0;
         motor_q        <= 1'b0;
         drain_q        <= 1'b0;
         door_lock_q    <= 1'b0;
         busy_q         <= 1'b0;
         cycle_done_q   <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         mode_q         <= mode_d;
         last_q         <= last_d;
         hold_q         <= hold_d;
         tmr_enable_q   <= is_phase(state_d);
         tmr_power_on_q <= is_phase(state_d) & run_ok;
         valve_q        <= run_ok & (state_d inside {S_SOAK, S_WASH, S_RINSE});
         motor_q        <= run_ok & (state_d inside {S_WASH, S_RINSE, S_SPIN});
         drain_q        <= run_ok & (state_d == S_SPIN);
         door_lock_q    <= (state_d != S_IDLE);
         busy_q         <= (state_d != S_IDLE);
         cycle_done_q   <= (state_d == S_DONE);
         fault_q        <= (state_d == S_FAULT);
      end
   end

   assign tmr_enable    = tmr_enable_q;
   assign tmr_power_on  = tmr_power_on_q;
   assign tmr_phase_sel = phase_q;
   assign tmr_mode      = mode_q;
   assign valve_open    = valve_q;
   assign motor_on      = motor_q;
   assign drain_on      = drain_q;
   assign door_lock     = door_lock_q;
   assign busy          = busy_q;
   assign cycle_done    = cycle_done_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed program scenarios followed by
// randomized panel activity, all compared against a program-level model.
module tb_wash_cycle_sequencer;

   localparam int WDOG = 1024;
   localparam int HOLD = 4;

   logic clk = 1'b0;
   logic rst, start, mode1, mode2, mode3, mode4;
   logic power_on, door_closed, abort, fault_clr, timer_done_i;
   logic tmr_enable, tmr_power_on, valve_open, motor_on, drain_on;
   logic door_lock, busy, cycle_done, fault;
   logic [1:0] tmr_phase_sel;
   logic [3:0] tmr_mode;
   logic [14:0] dut_vec;

   always #5 clk = ~clk;

   wash_cycle_sequencer #(.WDOG_CYCLES(WDOG), .DONE_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mode1(mode1), .mode2(mode2), .mode3(mode3), .mode4(mode4),
      .power_on(power_on), .door_closed(door_closed), .abort(abort),
      .fault_clr(fault_clr), .timer_done_i(timer_done_i),
      .tmr_enable(tmr_enable), .tmr_power_on(tmr_power_on),
      .tmr_phase_sel(tmr_phase_sel), .tmr_mode(tmr_mode),
      .valve_open(valve_open), .motor_on(motor_on), .drain_on(drain_on),
      .door_lock(door_lock), .busy(busy), .cycle_done(cycle_done), .fault(fault)
   );

   assign dut_vec = {tmr_enable, tmr_power_on, tmr_phase_sel, tmr_mode, valve_open,
                     motor_on, drain_on, door_lock, busy, cycle_done, fault};

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Program-level model: st 0 idle, 1 running a phase, 2 between phases,
   // 3 finished, 4 faulted; prog is the list of phase codes for the program.
   int         m_st, pidx, wd, held;
   int         prog[$];
   logic [3:0] m_mode;
   logic [1:0] m_fph;
   logic       m_ro;
   int         n_tab[4];
   int         tcnt;
   bit         rnd_spur;

   function automatic logic [14:0] exp_vec();
      logic en, pw;
      logic [1:0] ph;
      en = (m_st == 1);
      pw = en & m_ro;
      case (m_st)
         0: ph = 2'd0;
         1: ph = 2'(prog[pidx]);
         2: ph = (pidx == prog.size() - 1) ? 2'(prog[pidx]) : 2'(prog[pidx + 1]);
         3: ph = 2'd3;
         default: ph = m_fph;
      endcase
      return {en, pw, ph, m_mode, pw & (ph != 2'd3), pw & (ph != 2'd0), pw & (ph == 2'd3),
              m_st != 0, m_st != 0, m_st == 3, m_st == 4};
   endfunction

   task automatic model_step();
      logic ro;
      logic [3:0] mv;
      ro = power_on & door_closed;
      mv = {mode1, mode2, mode3, mode4};
      if (rst) begin
         m_st = 0; m_mode = 4'd0; m_ro = 1'b0;
         return;
      end
      case (m_st)
         0: if (start && ro) begin
               if ($countones(mv) == 1) begin
                  m_mode = mv;
                  prog.delete();
                  if (mv == 4'b0001) prog.push_back(3);
                  else for (int i = 0; i < 4; i++) prog.push_back(i);
                  pidx = 0; wd = 0; m_st = 1;
               end else begin
                  m_st = 4; m_fph = 2'd0;
               end
            end
         1: begin
               if (ro) wd++;
               if (abort) m_st = 0;
               else if (wd >= WDOG) begin m_st = 4; m_fph = 2'(prog[pidx]); end
               else if (timer_done_i) m_st = 2;
            end
         2: if (abort) m_st = 0;
            else if (pidx == prog.size() - 1) begin m_st = 3; held = 0; end
            else begin pidx++; wd = 0; m_st = 1; end
         3: if (abort) m_st = 0;
            else begin held++; if (held == HOLD) m_st = 0; end
         default: if (fault_clr && power_on) m_st = 0;
      endcase
      if (m_st == 0) m_mode = 4'd0;
      m_ro = ro;
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge,
   // then the phase-timer model decides the next timer_done_i.
   task automatic cycle();
      logic [14:0] ev;
      @(posedge clk);
      model_step();
      @(negedge clk);
      ev = exp_vec();
      check_eq("outs", dut_vec, ev);
      if (!ev[14]) tcnt = 0;
      else if (ev[13]) tcnt++;
      timer_done_i = 1'b0;
      if (ev[14] && ev[13] && n_tab[ev[12:11]] != 0 && tcnt >= n_tab[ev[12:11]]) begin
         timer_done_i = 1'b1;
         tcnt = 0;
      end
      if (rnd_spur && $urandom_range(99) == 0) timer_done_i = 1'b1;
   endtask

   task automatic set_mode(input logic [3:0] m);
      {mode1, mode2, mode3, mode4} = m;
   endtask

   task automatic start_prog(input logic [3:0] m);
      set_mode(m);
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic run_to_idle(input int max, output int dlen, output int gaps,
                              output int seq, output int pulses);
      int last;
      dlen = 0; gaps = 0; seq = 0; pulses = 0; last = -1;
      for (int k = 0; k < max && busy; k++) begin
         if (cycle_done) dlen++;
         if (!tmr_enable && !cycle_done && !fault) gaps++;
         if (tmr_enable && int'(tmr_phase_sel) != last) begin
            last = int'(tmr_phase_sel);
            seq  = seq * 10 + last + 1;
         end
         if (timer_done_i) pulses++;
         cycle();
      end
      check_eq("idle_reached", busy, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int dlen, gaps, seq, pulses, rc;
      rst = 1'b1; start = 1'b0; set_mode(4'd0); power_on = 1'b1; door_closed = 1'b1;
      abort = 1'b0; fault_clr = 1'b0; timer_done_i = 1'b0; rnd_spur = 1'b0;
      n_tab = '{10, 10, 10, 10}; tcnt = 0;
      m_st = 0; m_mode = 4'd0; m_fph = 2'd0; m_ro = 1'b0; pidx = 0; wd = 0; held = 0;
      cycle();
      cycle();
      check_eq("reset_outs", dut_vec, 15'd0);
      rst = 1'b0;
      cycle();

      // Normal program through all four phases.
      start_prog(4'b0100);
      check_eq("t1_lock", door_lock, 1'b1);
      run_to_idle(400, dlen, gaps, seq, pulses);
      check_eq("t1_seq", seq, 1234);
      check_eq("t1_gaps", gaps, 4);
      check_eq("t1_done_len", dlen, HOLD);
      check_eq("t1_unlock", door_lock, 1'b0);

      // Spin-only program.
      start_prog(4'b0001);
      check_eq("t2_spin", {motor_on, drain_on, valve_open, tmr_phase_sel}, 5'b11011);
      run_to_idle(200, dlen, gaps, seq, pulses);
      check_eq("t2_seq", seq, 4);
      check_eq("t2_pulses", pulses, 1);
      check_eq("t2_done_len", dlen, HOLD);

      // Mains outage mid-WASH.
      start_prog(4'b0010);
      for (int k = 0; k < 100 && !(tmr_enable && tmr_phase_sel == 2'd1); k++) cycle();
      check_eq("t3_in_wash", {tmr_enable, tmr_phase_sel}, 3'b101);
      cycle(); cycle(); cycle();
      power_on = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         check_eq("t3_pause", {tmr_enable, tmr_power_on, valve_open, motor_on, tmr_phase_sel},
                  6'b100001);
      end
      power_on = 1'b1;
      cycle();
      check_eq("t3_resume", {valve_open, motor_on, tmr_power_on, tmr_phase_sel}, 5'b11101);
      run_to_idle(400, dlen, gaps, seq, pulses);
      check_eq("t3_done_len", dlen, HOLD);

      // Stuck timer in RINSE, with an outage that must not count.
      n_tab = '{3, 3, 0, 3};
      start_prog(4'b0100);
      for (int k = 0; k < 200 && !(tmr_enable && tmr_phase_sel == 2'd2); k++) cycle();
      rc = tmr_enable ? 1 : 0;
      for (int k = 0; k < 100; k++) begin cycle(); if (tmr_enable) rc++; end
      power_on = 1'b0;
      for (int k = 0; k < 20; k++) begin cycle(); if (tmr_enable) rc++; end
      power_on = 1'b1;
      for (int k = 0; k < 1200 && !fault; k++) begin cycle(); if (tmr_enable) rc++; end
      check_eq("t4_rinse_len", rc, WDOG + 20);
      check_eq("t4_fault", {fault, door_lock, tmr_enable}, 3'b110);
      fault_clr = 1'b1; power_on = 1'b0;
      cycle();
      check_eq("t4_clr_ignored", fault, 1'b1);
      power_on = 1'b1;
      cycle();
      check_eq("t4_clr", {fault, busy}, 2'b00);
      fault_clr = 1'b0;
      n_tab = '{10, 10, 10, 10};

      // abort and timer_done_i together in SOAK.
      start_prog(4'b1000);
      cycle(); cycle();
      abort = 1'b1; timer_done_i = 1'b1;
      cycle();
      abort = 1'b0;
      check_eq("t5_abort_idle", dut_vec, 15'd0);

      // Invalid mode, door open, reset mid-SPIN.
      start_prog(4'b0110);
      check_eq("t6_invalid", {fault, door_lock}, 2'b11);
      fault_clr = 1'b1; cycle(); fault_clr = 1'b0;
      door_closed = 1'b0;
      start_prog(4'b0100);
      check_eq("t6_door", busy, 1'b0);
      door_closed = 1'b1;
      start_prog(4'b0001);
      cycle(); cycle();
      check_eq("t6_in_spin", drain_on, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("t6_rst", dut_vec, 15'd0);

      // Randomized panel activity.
      rnd_spur = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if (k % 200 == 0) for (int i = 0; i < 4; i++) n_tab[i] = $urandom_range(12, 2);
         start = ($urandom_range(9) == 0);
         if ($urandom_range(9) < 7) set_mode(4'(1 << $urandom_range(3)));
         else set_mode(4'($urandom_range(15)));
         power_on    = ($urandom_range(19) != 0);
         door_closed = ($urandom_range(29) != 0);
         abort       = ($urandom_range(99) == 0);
         fault_clr   = ($urandom_range(9) == 0);
         rst         = ($urandom_range(499) == 0);
         cycle();
      end
      rnd_spur = 1'b0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; fault_clr = 1'b0;
      power_on = 1'b1; door_closed = 1'b1;
      cycle(); cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
